// File: rtl/mp_alu_seq.sv
// mp_alu_seq: multi-precision add/subtract sequencer driving an external
// combinational 32-bit ALU, one word per pass, least-significant word first.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   start, sub, len      command strobe (IDLE only), 0=add/1=sub, word count
//                        (1-7, 0 means 8)
//   busy                 high whenever not IDLE
//   in_valid/in_ready    operand word handshake carrying in_a, in_b
//   alu_a, alu_b,        operands and control for the external ALU
//   alu_op, alu_cin      (op: add=2'b00, addc=2'b01, sub=2'b10, subc=2'b11)
//   alu_result,          ALU response; subtract forms compute a+~b+1 (sub)
//   alu_cout, alu_ovfl   or a+~b+cin (subc), cout=1 means no borrow
//   res_valid/res_ready  result word handshake carrying res_word, res_last
//   done, cout, ovfl     one-cycle completion pulse and final flags
//
// Optional feature: define MP_ALU_SEQ_ABORT_EN to add an abort input that
// returns the block to IDLE from any active state without a done pulse.

module mp_alu_seq #(
    parameter int WORDS_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
`ifdef MP_ALU_SEQ_ABORT_EN
    input  logic        abort,
`endif
    input  logic        start,
    input  logic        sub,
    input  logic [2:0]  len,
    output logic        busy,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [1:0]  alu_op,
    output logic        alu_cin,
    input  logic [31:0] alu_result,
    input  logic        alu_cout,
    input  logic        alu_ovfl,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_word,
    output logic        res_last,
    output logic        done,
    output logic        cout,
    output logic        ovfl
);

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_ADDC = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_SUBC = 2'b11;

    // Counter must hold the full word count (8), not just 0..7.
    localparam int CW = $clog2(WORDS_MAX + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        EMIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t          state;
    logic            sub_r;
    logic [CW-1:0]   len_r;
    logic [CW-1:0]   cnt;
    logic            carry_r;
    logic            ovfl_r;    // ovfl of the most recent word; last word's wins

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sub_r     <= 1'b0;
            len_r     <= '0;
            cnt       <= '0;
            carry_r   <= 1'b0;
            ovfl_r    <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= OP_ADD;
            alu_cin   <= 1'b0;
            res_valid <= 1'b0;
            res_word  <= '0;
            res_last  <= 1'b0;
            done      <= 1'b0;
            cout      <= 1'b0;
            ovfl      <= 1'b0;
        end
`ifdef MP_ALU_SEQ_ABORT_EN
        else if (abort && state != IDLE) begin
            // Drop the operation; final flags keep the previous result.
            state     <= IDLE;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            res_valid <= 1'b0;
            res_last  <= 1'b0;
            done      <= 1'b0;
        end
`endif
        else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sub_r    <= sub;
                        len_r    <= (len == 3'd0) ? CW'(WORDS_MAX) : CW'(len);
                        cnt      <= '0;
                        carry_r  <= 1'b0;
                        busy     <= 1'b1;
                        in_ready <= 1'b1;
                        state    <= FETCH;
                    end
                end

                FETCH: begin
                    if (in_valid) begin
                        alu_a    <= in_a;
                        alu_b    <= in_b;
                        // ALU controls are registered here so they are
                        // stable for the whole EXEC cycle.
                        if (cnt == '0) begin
                            alu_op  <= sub_r ? OP_SUB : OP_ADD;
                            alu_cin <= 1'b0;
                        end else begin
                            alu_op  <= sub_r ? OP_SUBC : OP_ADDC;
                            alu_cin <= carry_r;
                        end
                        in_ready <= 1'b0;
                        state    <= EXEC;
                    end
                end

                EXEC: begin
                    res_word  <= alu_result;
                    carry_r   <= alu_cout;
                    ovfl_r    <= alu_ovfl;
                    cnt       <= cnt + CW'(1);
                    res_last  <= ((cnt + CW'(1)) == len_r);
                    res_valid <= 1'b1;
                    state     <= EMIT;
                end

                EMIT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        res_last  <= 1'b0;
                        if (res_last) begin
                            done  <= 1'b1;
                            cout  <= carry_r;
                            ovfl  <= ovfl_r;
                            state <= DONE;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= FETCH;
                        end
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mp_alu_seq.md
MP_ALU_SEQ -- requirements
Module: mp_alu_seq

Interface
REQ-001 The block SHALL have parameter WORDS_MAX, default 8, the maximum number of 32-bit words per multi-precision operation; len encoding limits it to 8.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port start  input  1  command strobe, sampled only in IDLE.
REQ-005 The block SHALL have port sub  input  1  command: 0 selects multi-word add, 1 selects multi-word subtract; latched at start.
REQ-006 The block SHALL have port len  input  3  word count, latched at start: 1-7 means that many words, 0 means 8 words.
REQ-007 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-008 The block SHALL have ports in_valid  input  1, in_ready  output  1, in_a  input  32 and in_b  input  32, forming the operand word handshake, least-significant word first.
REQ-009 The block SHALL have ports alu_a  output  32, alu_b  output  32, alu_op  output  2 and alu_cin  output  1, which drive the combinational ALU, using the ALU's `add/`addc/`sub/`subc encodings.
REQ-010 The block SHALL have ports alu_result  input  32, alu_cout  input  1 and alu_ovfl  input  1, the ALU responses.
REQ-011 The block SHALL have ports res_valid  output  1, res_ready  input  1, res_word  output  32 and res_last  output  1, forming the result word handshake.
REQ-012 The block SHALL have ports done  output  1, cout  output  1 and ovfl  output  1, giving operation completion and final flags.

Function
REQ-013 The block SHALL implement the states IDLE, FETCH, EXEC, EMIT and DONE.
REQ-014 IDLE: start=1 SHALL latch sub and len, clear the word counter and carry_r, and move to FETCH; start in any other state SHALL be ignored.
REQ-015 FETCH: in_ready SHALL be 1, and only in this state; on in_valid=1 the block SHALL register in_a and in_b into alu_a and alu_b and go to EXEC.
REQ-016 EXEC (exactly 1 cycle): for the first word, alu_op SHALL be `add (sub=0) or `sub (sub=1) and alu_cin SHALL be 0.
REQ-017 EXEC: for later words, alu_op SHALL be `addc or `subc and alu_cin SHALL be carry_r.
REQ-018 EXEC: the block SHALL capture alu_result into res_word and alu_cout into carry_r, capture alu_ovfl, increment the counter, and go to EMIT.
REQ-019 ALU contract: `sub and `subc SHALL compute a+~b+1 and a+~b+cin respectively, with cout=1 meaning no borrow.
REQ-020 EMIT: res_valid SHALL be 1, and res_last SHALL be 1 iff counter equals the latched length (8 when len=0).
REQ-021 EMIT: res_word and res_last SHALL stay stable until res_ready=1.
REQ-022 EMIT: on handshake, the block SHALL go to DONE if res_last=1, else to FETCH.
REQ-023 DONE: done SHALL be 1 for exactly one cycle and the block SHALL then return to IDLE.
REQ-024 cout and ovfl SHALL take carry_r and the last word's ovfl on entry to DONE and hold until the next accepted start.
REQ-025 Minimum throughput SHALL be 3 cycles per word; the block SHALL not overlap operations.
REQ-026 alu_op and alu_cin outside EXEC SHALL hold the last driven values, which have no meaning.

Reset
REQ-027 While rst=1 at a clock edge, the block SHALL enter IDLE and clear every output and internal register to 0: busy, in_ready, res_valid, res_last, res_word, done, cout, ovfl, alu_a, alu_b, alu_op, alu_cin, carry_r and the counter.
REQ-028 Reset mid-operation SHALL discard the operation with no done pulse; rst SHALL override start in the same cycle.

Configuration
REQ-029 With macro MP_ALU_SEQ_ABORT_EN defined, the block SHALL add port abort  input  1; abort=1 in any non-IDLE state SHALL send the block to IDLE on the next edge with no done pulse.
REQ-030 With MP_ALU_SEQ_ABORT_EN defined, aborting SHALL deassert res_valid and in_ready on the next edge and leave cout and ovfl unchanged.
REQ-031 Without MP_ALU_SEQ_ABORT_EN, the abort port SHALL be absent and an operation SHALL end only via DONE or reset.

Verification
REQ-032 The bench SHALL cover: len=1, sub=0, a=15, b=15 -> alu_op=`add, alu_cin=0, res_word=30, res_last=1, then done pulse with cout=0, ovfl=0.
REQ-033 The bench SHALL cover: len=2 add, words (FFFF_FFFF,1) then (0,0) -> res_word 0 then 1, second EXEC with alu_op=`addc and alu_cin=1, final cout=0.
REQ-034 The bench SHALL cover: len=2 sub, words (0,1) then (1,0) -> res_word FFFF_FFFF with carry_r=0, then 0000_0000 with alu_op=`subc and alu_cin=0, final cout=1.
REQ-035 The bench SHALL cover: res_ready held low 5 cycles in EMIT -> res_valid=1 and res_word/res_last stable, with in_ready=0 throughout.
REQ-036 The bench SHALL cover: len=0 -> exactly 8 result words, res_last only on the 8th, one done pulse; a start while busy is ignored.
REQ-037 The bench SHALL cover: rst=1 during word 2 (and abort=1 when MP_ALU_SEQ_ABORT_EN is defined) -> IDLE next edge, all outputs 0 (abort: cout/ovfl unchanged), no done pulse.
